// File: rtl/fcpu_pkg.sv
// Shared types and opcode decode for the memory access unit.
package fcpu_pkg;

  localparam int DATA_W   = 32;
  localparam int INSTR_W  = 6;
  localparam int RSV_ID_W = 4;
  localparam int CDB_W    = RSV_ID_W + 32;
  localparam int AXI_ID_W = 4;

  localparam logic [INSTR_W-1:0] OP_NOP     = 6'd0;
  localparam logic [INSTR_W-1:0] OP_LOAD    = 6'd1;
  localparam logic [INSTR_W-1:0] OP_LOADB   = 6'd2;
  localparam logic [INSTR_W-1:0] OP_LOADR   = 6'd3;
  localparam logic [INSTR_W-1:0] OP_LOADT   = 6'd4;
  localparam logic [INSTR_W-1:0] OP_LOADTB  = 6'd5;
  localparam logic [INSTR_W-1:0] OP_STORE   = 6'd6;
  localparam logic [INSTR_W-1:0] OP_STOREB  = 6'd7;
  localparam logic [INSTR_W-1:0] OP_STORER  = 6'd8;
  localparam logic [INSTR_W-1:0] OP_STORET  = 6'd9;
  localparam logic [INSTR_W-1:0] OP_STORETB = 6'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_CDB
  } mmu_state_t;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [INSTR_W-1:0]  opcode;
    logic [DATA_W-1:0]   address;
    logic [DATA_W-1:0]   data;
  } mmu_req_t;

  function automatic logic mmu_is_load(input logic [INSTR_W-1:0] op);
    return op inside {OP_LOAD, OP_LOADB, OP_LOADR, OP_LOADT, OP_LOADTB};
  endfunction

  function automatic logic mmu_is_store(input logic [INSTR_W-1:0] op);
    return op inside {OP_STORE, OP_STOREB, OP_STORER, OP_STORET, OP_STORETB};
  endfunction

  function automatic logic mmu_is_byte(input logic [INSTR_W-1:0] op);
    return op inside {OP_LOADT, OP_LOADTB, OP_STORET, OP_STORETB};
  endfunction

endpackage

// File: rtl/mmu_queued_access_fifo.sv
// In-order request queue (module mmu_req_fifo): DEPTH entries of mmu_req_t.
module mmu_req_fifo
  import fcpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mmu_req_t din,
  input  logic     pop,
  output mmu_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  mmu_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmu_queued_access.sv
// Queued memory access unit: in-order single-beat AXI issue to CRAM/GMEM, CDB result stage.
// Optional MMU_STORE_ACK_EN: stores post {rsv_id,0} on the CDB.
module mmu_queued_access
  import fcpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int N_BANK      = 4,
  parameter int CRAM_ADDR_W = 16,
  parameter int GADDR_W     = 28,
  localparam int GW = DATA_W * N_BANK,
  localparam int SW = GW / 8,
  localparam int LB = $clog2(SW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RSV_ID_W-1:0]    rsv_id,
  input  logic                   valid,
  input  logic [INSTR_W-1:0]     opcode,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      data,
  output logic                   ready,
  output logic [AXI_ID_W-1:0]    g_awid,
  output logic [GADDR_W-1:0]     g_awaddr,
  output logic [7:0]             g_awlen,
  output logic [2:0]             g_awsize,
  output logic [1:0]             g_awburst,
  output logic                   g_awlock,
  output logic [3:0]             g_awcache,
  output logic [2:0]             g_awprot,
  output logic [3:0]             g_awqos,
  output logic                   g_awvalid,
  input  logic                   g_awready,
  output logic [GW-1:0]          g_wdata,
  output logic [SW-1:0]          g_wstrb,
  output logic                   g_wlast,
  output logic                   g_wvalid,
  input  logic                   g_wready,
  input  logic [1:0]             g_bresp,
  input  logic                   g_bvalid,
  output logic                   g_bready,
  output logic [AXI_ID_W-1:0]    g_arid,
  output logic [GADDR_W-1:0]     g_araddr,
  output logic [7:0]             g_arlen,
  output logic [2:0]             g_arsize,
  output logic [1:0]             g_arburst,
  output logic                   g_arlock,
  output logic [3:0]             g_arcache,
  output logic [2:0]             g_arprot,
  output logic [3:0]             g_arqos,
  output logic                   g_arvalid,
  input  logic                   g_arready,
  input  logic [GW-1:0]          g_rdata,
  input  logic [1:0]             g_rresp,
  input  logic                   g_rvalid,
  output logic                   g_rready,
  output logic [AXI_ID_W-1:0]    c_arid,
  output logic [CRAM_ADDR_W-1:0] c_araddr,
  output logic [7:0]             c_arlen,
  output logic [2:0]             c_arsize,
  output logic [1:0]             c_arburst,
  output logic                   c_arlock,
  output logic [3:0]             c_arcache,
  output logic [2:0]             c_arprot,
  output logic [3:0]             c_arqos,
  output logic                   c_arvalid,
  input  logic                   c_arready,
  input  logic [31:0]            c_rdata,
  input  logic [1:0]             c_rresp,
  input  logic                   c_rvalid,
  output logic                   c_rready,
  output logic [CDB_W-1:0]       o_cdb,
  output logic                   o_cdb_valid,
  input  logic                   o_cdb_ready,
  output logic                   bus_err,
  output logic                   cram_wr_err
);

  function automatic logic is_cram(input logic [DATA_W-1:0] a);
    return (a >> CRAM_ADDR_W) == '0;
  endfunction

  mmu_state_t st, nxt;
  mmu_req_t   head, cur, req;
  logic       full, empty, pop;
  logic       aw_done, w_done, aw_hs, w_hs;
  logic       cur_cram, head_cram_st;
  logic [LB-1:0] off, k;
  logic [31:0]   g_word, rd_res;
  logic [7:0]    g_byte;

  assign req   = '{rsv_id: rsv_id, opcode: opcode, address: address, data: data};
  assign ready = !full;

  mmu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(valid && ready), .din(req),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );

  assign cur_cram     = is_cram(cur.address);
  assign head_cram_st = mmu_is_store(head.opcode) && is_cram(head.address);

  // constant single-beat INCR attributes
  assign g_awid = '0;  assign g_awlen = '0;  assign g_awsize = 3'(LB);
  assign g_awburst = 2'b01;  assign g_awlock = 1'b0;  assign g_awcache = '0;
  assign g_awprot = '0;  assign g_awqos = '0;  assign g_wlast = 1'b1;
  assign g_arid = '0;  assign g_arlen = '0;  assign g_arsize = 3'(LB);
  assign g_arburst = 2'b01;  assign g_arlock = 1'b0;  assign g_arcache = '0;
  assign g_arprot = '0;  assign g_arqos = '0;
  assign c_arid = '0;  assign c_arlen = '0;  assign c_arsize = 3'd2;
  assign c_arburst = 2'b01;  assign c_arlock = 1'b0;  assign c_arcache = '0;
  assign c_arprot = '0;  assign c_arqos = '0;

  assign g_awaddr    = cur.address[GADDR_W-1:0];
  assign g_araddr    = cur.address[GADDR_W-1:0];
  assign c_araddr    = cur.address[CRAM_ADDR_W-1:0];
  assign g_awvalid   = (st == S_WR) && !aw_done;
  assign g_wvalid    = (st == S_WR) && !w_done;
  assign g_bready    = (st == S_WR_RESP);
  assign g_arvalid   = (st == S_RD_ADDR) && !cur_cram;
  assign c_arvalid   = (st == S_RD_ADDR) && cur_cram;
  assign g_rready    = (st == S_RD_DATA) && !cur_cram;
  assign c_rready    = (st == S_RD_DATA) && cur_cram;
  assign o_cdb_valid = (st == S_CDB);
  assign aw_hs       = g_awvalid && g_awready;
  assign w_hs        = g_wvalid && g_wready;

  // lane select: k is the 32-bit lane, off the byte within the beat
  assign off    = cur.address[LB-1:0];
  assign k      = off >> 2;
  assign g_word = 32'(g_rdata >> {k, 5'b0});
  assign g_byte = 8'(g_rdata >> {off, 3'b0});

  always_comb begin
    if (mmu_is_byte(cur.opcode)) begin
      g_wstrb = SW'(1) << off;
      g_wdata = {SW{cur.data[7:0]}};
    end else begin
      g_wstrb = SW'(4'hF) << {k, 2'b00};
      g_wdata = {N_BANK{cur.data}};
    end
    if (cur_cram)                    rd_res = c_rdata;
    else if (mmu_is_byte(cur.opcode)) rd_res = {24'h0, g_byte};
    else                             rd_res = g_word;
  end

  always_comb begin
    nxt = st;
    pop = 1'b0;
    case (st)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        if (mmu_is_store(head.opcode)) begin
`ifdef MMU_STORE_ACK_EN
          nxt = head_cram_st ? S_CDB : S_WR;
`else
          nxt = head_cram_st ? S_IDLE : S_WR;
`endif
        end else if (mmu_is_load(head.opcode)) begin
          nxt = S_RD_ADDR;
        end
      end
      S_WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) nxt = S_WR_RESP;
`ifdef MMU_STORE_ACK_EN
      S_WR_RESP: if (g_bvalid) nxt = S_CDB;
`else
      S_WR_RESP: if (g_bvalid) nxt = S_IDLE;
`endif
      S_RD_ADDR: if (cur_cram ? c_arready : g_arready) nxt = S_RD_DATA;
      S_RD_DATA: if (cur_cram ? c_rvalid : g_rvalid) nxt = S_CDB;
      S_CDB:     if (o_cdb_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      cur         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      o_cdb       <= '0;
      bus_err     <= 1'b0;
      cram_wr_err <= 1'b0;
    end else begin
      st          <= nxt;
      cram_wr_err <= (st == S_IDLE) && pop && head_cram_st;
      if (pop) cur <= head;
      if (st == S_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (nxt == S_CDB && st == S_RD_DATA) o_cdb <= {cur.rsv_id, rd_res};
`ifdef MMU_STORE_ACK_EN
      if (nxt == S_CDB && st == S_WR_RESP) o_cdb <= {cur.rsv_id, 32'h0};
      if (nxt == S_CDB && st == S_IDLE)    o_cdb <= {head.rsv_id, 32'h0};
`endif
      if ((g_bvalid && g_bready && g_bresp != 2'b00) ||
          (g_rvalid && g_rready && g_rresp != 2'b00) ||
          (c_rvalid && c_rready && c_rresp != 2'b00))
        bus_err <= 1'b1;
    end
  end

endmodule
